// File: rtl/png_idat_wr.sv
// png_idat_wr: drains the compressed-data byte fifo and wraps it into one
// PNG IDAT chunk (4-byte length, "IDAT", data bytes, CRC-32). The chunk is
// presented as a byte stream with a valid/ready handshake.
// Optional feature macro: IDAT_CRC_EN. When it is defined, the CRC-32 over
// type and data bytes is computed and sent. When it is not defined, the CRC
// field is sent as four zero bytes and the CRC logic is not built.
module png_idat_wr #(
    parameter int LEN_WD = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic [LEN_WD-1:0] len_i,
    input  logic              fif_ept_i,
    input  logic              fif_wr_i,
    output logic              fif_rd_o,
    input  logic              fif_val_i,
    input  logic [7:0]        fif_dat_i,
    output logic              out_val_o,
    output logic [7:0]        out_dat_o,
    input  logic              out_rdy_i,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [2:0] {IDLE, LEN, TYP, DAT, CRC} state_t;

    state_t            state_q, state_d;
    logic [LEN_WD-1:0] len_q, len_d;
    logic [LEN_WD-1:0] cnt_q, cnt_d;        // accepted bytes in the current phase
    logic [LEN_WD-1:0] rd_cnt_q, rd_cnt_d;  // fifo reads issued in this chunk
    logic [7:0]        hld_q [2];
    logic [7:0]        hld_d [2];
    logic [1:0]        hld_cnt_q, hld_cnt_d;
    logic              done_q, done_d;

    logic [31:0] len32;
    logic [31:0] crc_out;
    logic        val;
    logic [7:0]  dat;
    logic        acc;
    logic        pop;
    logic        push;
    logic        rd_en;
    logic        hdr_last;
    logic [1:0]  base;
    logic [2:0]  occ;
    logic [2:0]  lim;

    assign len32    = 32'(len_q);
    assign hdr_last = (cnt_q == LEN_WD'(3));

    // Select the byte on the output port from the current phase and position.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        val = 1'b0;
        dat = 8'h00;
        case (state_q)
            LEN: begin
                val = 1'b1;
                case (cnt_q[1:0])
                    2'd0:    dat = len32[31:24];
                    2'd1:    dat = len32[23:16];
                    2'd2:    dat = len32[15:8];
                    default: dat = len32[7:0];
                endcase
            end
            TYP: begin
                val = 1'b1;
                case (cnt_q[1:0])
                    2'd0:    dat = 8'h49;
                    2'd1:    dat = 8'h44;
                    2'd2:    dat = 8'h41;
                    default: dat = 8'h54;
                endcase
            end
            DAT: begin
                val = (hld_cnt_q != 2'd0);
                dat = val ? hld_q[0] : 8'h00;
            end
            CRC: begin
                val = 1'b1;
                case (cnt_q[1:0])
                    2'd0:    dat = crc_out[31:24];
                    2'd1:    dat = crc_out[23:16];
                    2'd2:    dat = crc_out[15:8];
                    default: dat = crc_out[7:0];
                endcase
            end
            default: ;
        endcase
    end

    assign acc  = val & out_rdy_i;
    assign pop  = acc & (state_q == DAT);
    // A late read return after the data phase is impossible; outside DAT it is ignored.
    assign push = fif_val_i & (state_q == DAT);

    // Occupancy the hold buffer will have next cycle must stay below two for a new read.
    assign occ   = {1'b0, hld_cnt_q} + {2'b00, fif_val_i};
    assign lim   = 3'd2 + {2'b00, pop};
    assign rd_en = (state_q == DAT) && (rd_cnt_q < len_q) && !fif_ept_i
                   && !fif_wr_i && (occ < lim);

    // Hold buffer: pop the head on acceptance, append the returning fifo byte behind it.
    always_comb begin
        hld_d     = hld_q;
        base      = hld_cnt_q;
        hld_cnt_d = hld_cnt_q;
        if (pop) begin
            hld_d[0] = hld_q[1];
            base     = hld_cnt_q - 2'd1;
        end
        if (push) begin
            hld_d[base[0]] = fif_dat_i;
        end
        hld_cnt_d = base + {1'b0, push};
    end

    // Phase sequencing, byte counters and the completion pulse.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        rd_cnt_d = rd_cnt_q + LEN_WD'(rd_en);
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = LEN;
                    len_d    = len_i;
                    cnt_d    = '0;
                    rd_cnt_d = '0;
                end
            end
            LEN: begin
                if (acc) begin
                    cnt_d   = hdr_last ? '0 : cnt_q + LEN_WD'(1);
                    state_d = hdr_last ? TYP : LEN;
                end
            end
            TYP: begin
                if (acc) begin
                    cnt_d = hdr_last ? '0 : cnt_q + LEN_WD'(1);
                    if (hdr_last) begin
                        state_d = (len_q == '0) ? CRC : DAT;
                    end
                end
            end
            DAT: begin
                if (acc) begin
                    if (cnt_q == len_q - LEN_WD'(1)) begin
                        state_d = CRC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + LEN_WD'(1);
                    end
                end
            end
            CRC: begin
                if (acc) begin
                    cnt_d = hdr_last ? '0 : cnt_q + LEN_WD'(1);
                    if (hdr_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and hold buffer registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            state_q   <= IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            rd_cnt_q  <= '0;
            hld_cnt_q <= 2'd0;
            // NOTE: the two-entry hold buffer is plain flops, so it is cleared with the rest on reset.
            hld_q[0]  <= 8'h00;
            hld_q[1]  <= 8'h00;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            hld_cnt_q <= hld_cnt_d;
            hld_q[0]  <= hld_d[0];
            hld_q[1]  <= hld_d[1];
            done_q    <= done_d;
        end
    end

`ifdef IDAT_CRC_EN
    logic [31:0] crc_q, crc_d;

    // Reflected CRC-32 (poly 0xEDB88320) advanced by one byte, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'h000000, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    // Fold each accepted type/data byte into the running CRC; a new chunk restarts it.
    always_comb begin
        crc_d = crc_q;
        if (state_q == IDLE && start_i) begin
            crc_d = 32'hFFFF_FFFF;
        end else if (acc && (state_q == TYP || state_q == DAT)) begin
            crc_d = crc_byte(crc_q, dat);
        end
    end

    // CRC register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            crc_q <= 32'hFFFF_FFFF;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = ~crc_q;
`else
    assign crc_out = 32'h0000_0000;
`endif

    assign fif_rd_o  = rd_en;
    assign out_val_o = val;
    assign out_dat_o = dat;
    assign busy_o    = (state_q != IDLE);
    assign done_o    = done_q;

endmodule
